// File: rtl/pry2oht_rr_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// Latency: none, plain wires.
// Backpressure: ack from the consumer side; the arbiter holds its grant until ack.
//
// Ports:
//   req : one bit per requester, held until that requester is granted and acked
//   ack : the downstream side accepts the current grant this cycle
//   oht : one-hot grant
//   bin : binary index of oht, 0 when nothing is granted
//   vld : a grant is present (|oht)
interface pry2oht_rr_if #(
    parameter int WIDTH = 8
);
    localparam int BW = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic             ack;
    logic [WIDTH-1:0] oht;
    logic [BW-1:0]    bin;
    logic             vld;

    // Requester / consumer side.
    modport master (
        output req,
        output ack,
        input  oht,
        input  bin,
        input  vld
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  ack,
        output oht,
        output bin,
        output vld
    );
endinterface

// File: rtl/pry2oht_rr.sv
// Registered round-robin arbiter: one-hot + binary grant out of WIDTH requests.
// Latency: req->grant combinational; mask/lock state updates on the next clk edge.
// Backpressure: an un-acked grant is locked and held until ack or until its request drops.
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset; grant outputs are forced to 0 while high
//   bus : pry2oht_rr_if slave (req, ack in; oht, bin, vld out)

// Priority-to-one-hot converter: keeps only the highest-priority set bit.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   req : request vector
//   oht : one-hot of the winning request, '0 when req is '0
module pry2oht #(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 3,
    parameter     DIRECTION      = "LSB",
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht
);
    // All implementations below are written LSB-first; for MSB priority the
    // vector is mirrored on the way in and on the way out.
    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] o_l;

    for (genvar i = 0; i < WIDTH; i++) begin : g_dir
        if (DIRECTION == "MSB") begin : g_msb
            assign r_l[i] = req[WIDTH-1-i];
            assign oht[i] = o_l[WIDTH-1-i];
        end else begin : g_lsb
            assign r_l[i] = req[i];
            assign oht[i] = o_l[i];
        end
    end

    if (IMPLEMENTATION == 1) begin : g_tree
        // Two-level tree: SPLIT-bit groups first pick a winning group, then a
        // winning bit inside it.
        localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;

        logic [NG-1:0] g_any;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            localparam int LO = g * SPLIT;
            localparam int HI = (LO + SPLIT - 1 < WIDTH) ? LO + SPLIT - 1 : WIDTH - 1;

            logic below;  // some lower group already has a request
            logic g_win;

            assign g_any[g] = |r_l[HI:LO];

            if (g == 0) begin : g_first
                assign below = 1'b0;
            end else begin : g_rest
                assign below = |g_any[g-1:0];
            end

            assign g_win = g_any[g] & ~below;

            for (genvar j = LO; j <= HI; j++) begin : g_bit
                if (j == LO) begin : g_lo
                    assign o_l[j] = g_win & r_l[j];
                end else begin : g_hi
                    assign o_l[j] = g_win & r_l[j] & ~(|r_l[j-1:LO]);
                end
            end
        end
    end else if (IMPLEMENTATION == 2) begin : g_adder
        // Two's-complement isolate-lowest-set-bit.
        assign o_l = r_l & (~r_l + WIDTH'(1));
    end else begin : g_loop
        // Ripple scan. Once a winner is found, every later (lower priority)
        // bit is ANDed with 0, so an X there cannot reach the output.
        always_comb begin
            logic found;
            found = 1'b0;
            o_l   = '0;
            for (int i = 0; i < WIDTH; i++) begin
                o_l[i] = r_l[i] & ~found;
                found  = found | r_l[i];
            end
        end
    end
endmodule

module pry2oht_rr #(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 3,
    parameter     DIRECTION      = "LSB",
    parameter int IMPLEMENTATION = 0,
    parameter     MODE           = "RR"
) (
    input  logic         clk,
    input  logic         rst,
    pry2oht_rr_if.slave  bus
);
    localparam int BW      = $clog2(WIDTH);
    localparam bit ROTATE  = (MODE == "RR");
    localparam bit PRI_MSB = (DIRECTION == "MSB");

    // State.
    logic [WIDTH-1:0] msk;      // requesters still eligible this round
    logic             lck;      // an un-acked grant is being held
    logic [WIDTH-1:0] hld;      // the held one-hot grant

    logic [WIDTH-1:0] msk_nxt;
    logic             lck_nxt;
    logic [WIDTH-1:0] hld_nxt;

    // Arbitration.
    logic [WIDTH-1:0] mreq;
    logic [WIDTH-1:0] oht_m;    // winner among masked requests
    logic [WIDTH-1:0] oht_u;    // winner among all requests
    logic [WIDTH-1:0] oht_arb;
    logic [WIDTH-1:0] oht_int;
    logic [BW-1:0]    bin_int;
    logic             vld_int;
    logic             locked;

    assign mreq = bus.req & msk;

    pry2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .DIRECTION      (DIRECTION),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_msk (
        .req (mreq),
        .oht (oht_m)
    );

    pry2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .DIRECTION      (DIRECTION),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_all (
        .req (bus.req),
        .oht (oht_u)
    );

    always_comb begin
        // An empty masked set means the round is exhausted (including the
        // wrapped msk='0 case), so fall back to the full request vector.
        oht_arb = (|mreq) ? oht_m : oht_u;

        // The lock only counts while the held requester is still asking;
        // if it drops, we re-arbitrate in the same cycle.
        locked = lck & (|(bus.req & hld));

        if (rst) begin
            oht_int = '0;
        end else if (locked) begin
            oht_int = hld;
        end else begin
            oht_int = oht_arb;
        end

        vld_int = |oht_int;

        bin_int = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oht_int[i]) begin
                bin_int = bin_int | BW'(i);
            end
        end
    end

    assign bus.oht = oht_int;
    assign bus.bin = bin_int;
    assign bus.vld = vld_int;

    // Next state.
    always_comb begin
        msk_nxt = msk;
        lck_nxt = 1'b0;
        hld_nxt = '0;

        if (vld_int && bus.ack) begin
            if (ROTATE) begin
                if (PRI_MSB) begin
                    // Bits strictly below the granted one.
                    msk_nxt = oht_int - WIDTH'(1);
                end else begin
                    // Bits strictly above the granted one; '0 after the top bit.
                    msk_nxt = ~(oht_int | (oht_int - WIDTH'(1)));
                end
            end
        end else if (vld_int) begin
            lck_nxt = 1'b1;
            hld_nxt = oht_int;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msk <= '1;
            lck <= 1'b0;
            hld <= '0;
        end else begin
            msk <= msk_nxt;
            lck <= lck_nxt;
            hld <= hld_nxt;
        end
    end
endmodule

// File: tb/tb_pry2oht_rr.sv
// Bench for pry2oht_rr: three DUT variants (RR/LSB, FIXED/LSB, RR/MSB) share one
// stimulus stream and are compared against a pointer-based reference model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pry2oht_rr;
    logic       clk = 1'b0;
    logic       rst_d = 1'b1;
    logic [3:0] req_d = 4'h0;
    logic       ack_d = 1'b0;

    always #5 clk = ~clk;

    pry2oht_rr_if #(.WIDTH(4)) if_l ();
    pry2oht_rr_if #(.WIDTH(4)) if_f ();
    pry2oht_rr_if #(.WIDTH(4)) if_m ();

    assign if_l.req = req_d;
    assign if_l.ack = ack_d;
    assign if_f.req = req_d;
    assign if_f.ack = ack_d;
    assign if_m.req = req_d;
    assign if_m.ack = ack_d;

    pry2oht_rr #(.WIDTH(4), .SPLIT(3), .DIRECTION("LSB"), .IMPLEMENTATION(0), .MODE("RR"))
        dut_l (.clk(clk), .rst(rst_d), .bus(if_l));
    pry2oht_rr #(.WIDTH(4), .SPLIT(3), .DIRECTION("LSB"), .IMPLEMENTATION(1), .MODE("FIXED"))
        dut_f (.clk(clk), .rst(rst_d), .bus(if_f));
    pry2oht_rr #(.WIDTH(4), .SPLIT(3), .DIRECTION("MSB"), .IMPLEMENTATION(2), .MODE("RR"))
        dut_m (.clk(clk), .rst(rst_d), .bus(if_m));

    logic [3:0] d_oht [3];
    logic [1:0] d_bin [3];
    logic       d_vld [3];

    assign d_oht[0] = if_l.oht;
    assign d_bin[0] = if_l.bin;
    assign d_vld[0] = if_l.vld;
    assign d_oht[1] = if_f.oht;
    assign d_bin[1] = if_f.bin;
    assign d_vld[1] = if_f.vld;
    assign d_oht[2] = if_m.oht;
    assign d_bin[2] = if_m.bin;
    assign d_vld[2] = if_m.vld;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a circular search pointer and an optional held index
    // per variant (0: RR/LSB, 1: FIXED/LSB, 2: RR/MSB).
    int         ptr      [3] = '{0, 0, 3};
    int         held     [3] = '{-1, -1, -1};
    int         g_cur    [3];
    bit         prev_hold[3] = '{0, 0, 0};
    int         prev_idx [3];
    logic [3:0] cur_oht  [3];
    logic [3:0] prev_oht [3];
    string      nm       [3] = '{"rr_lsb", "fixed", "rr_msb"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // First requester found scanning circularly from start (upward or downward).
    function automatic int pick(input logic [3:0] r, input int start, input bit down);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = down ? (start - k + 4) % 4 : (start + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive(input logic [3:0] r, input logic a, input logic rs);
        req_d = r;
        ack_d = a;
        rst_d = rs;
        @(negedge clk);
        for (int v = 0; v < 3; v++) begin
            int g;
            if (rs) g = -1;
            else if (held[v] >= 0 && r[held[v]]) g = held[v];
            else g = pick(r, ptr[v], v == 2);
            g_cur[v]   = g;
            cur_oht[v] = d_oht[v];
            chk($sformatf("%s_oht", nm[v]), 32'(d_oht[v]), (g < 0) ? 32'd0 : (32'd1 << g));
            chk($sformatf("%s_bin", nm[v]), 32'(d_bin[v]), (g < 0) ? 32'd0 : 32'(g));
            chk($sformatf("%s_vld", nm[v]), 32'(d_vld[v]), 32'(g >= 0));
            chk($sformatf("%s_onehot0", nm[v]), 32'($onehot0(d_oht[v])), 32'd1);
            chk($sformatf("%s_no_unreq", nm[v]), 32'(d_oht[v] & ~r), 32'd0);
            if (!rs)
                chk($sformatf("%s_vld_eq_anyreq", nm[v]), 32'(d_vld[v]), 32'(|r));
            if (prev_hold[v] && !rs && r[prev_idx[v]])
                chk($sformatf("%s_hold_stable", nm[v]), 32'(d_oht[v]), 32'(prev_oht[v]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int v = 0; v < 3; v++) begin
            int g;
            g = g_cur[v];
            if (rst_d) begin
                ptr[v]  = (v == 2) ? 3 : 0;
                held[v] = -1;
            end else if (g >= 0 && ack_d) begin
                held[v] = -1;
                if (v == 0) ptr[v] = (g + 1) % 4;
                if (v == 2) ptr[v] = (g + 3) % 4;
            end else if (g >= 0) begin
                held[v] = g;
            end else begin
                held[v] = -1;
            end
            prev_hold[v] = !rst_d && g >= 0 && !ack_d;
            prev_idx[v]  = g;
            prev_oht[v]  = cur_oht[v];
        end
        #1;
    endtask

    logic [3:0] rot_l [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rot_m [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] rr;
    logic       ra;
    logic       rrs;

    initial begin
        // Reset with all requests up: outputs forced low.
        drive(4'b1111, 1'b0, 1'b1);
        chk("rst_oht", 32'(d_oht[0]), 32'd0);
        chk("rst_vld", 32'(d_vld[0]), 32'd0);
        tick();
        drive(4'b1111, 1'b1, 1'b1);
        chk("rst2_oht", 32'(d_oht[2]), 32'd0);
        tick();
        drive(4'b0000, 1'b1, 1'b0);
        chk("idle_vld", 32'(d_vld[0]), 32'd0);
        tick();

        // Rotation with continuous ack, including wrap.
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk($sformatf("rot_l_oht%0d", i), 32'(d_oht[0]), 32'(rot_l[i]));
            chk($sformatf("rot_l_bin%0d", i), 32'(d_bin[0]), 32'(i % 4));
            chk($sformatf("fixed_oht%0d", i), 32'(d_oht[1]), 32'd1);
            chk($sformatf("rot_m_oht%0d", i), 32'(d_oht[2]), 32'(rot_m[i]));
            tick();
        end

        // Hold without ack; a new request must not preempt.
        for (int i = 0; i < 3; i++) begin
            drive(4'b1010, 1'b0, 1'b0);
            chk($sformatf("hold_oht%0d", i), 32'(d_oht[0]), 32'b0010);
            tick();
        end
        drive(4'b1011, 1'b0, 1'b0);
        chk("hold_nopreempt", 32'(d_oht[0]), 32'b0010);
        tick();
        drive(4'b1011, 1'b1, 1'b0);
        chk("hold_ack", 32'(d_oht[0]), 32'b0010);
        tick();
        drive(4'b1001, 1'b1, 1'b0);
        chk("after_ack", 32'(d_oht[0]), 32'b1000);
        tick();

        // Lock release when the held requester drops.
        drive(4'b1010, 1'b0, 1'b0);
        chk("lock_on", 32'(d_oht[0]), 32'b0010);
        tick();
        drive(4'b1000, 1'b0, 1'b0);
        chk("release_oht", 32'(d_oht[0]), 32'b1000);
        chk("release_vld", 32'(d_vld[0]), 32'd1);
        tick();
        drive(4'b1000, 1'b1, 1'b0);
        chk("release_ack", 32'(d_oht[0]), 32'b1000);
        tick();
        drive(4'b1111, 1'b1, 1'b0);
        chk("wrap_oht", 32'(d_oht[0]), 32'b0001);
        tick();

        // Reset in the middle of a lock.
        drive(4'b1111, 1'b1, 1'b1);
        tick();
        drive(4'b1111, 1'b1, 1'b0);
        chk("mid_g0", 32'(d_oht[0]), 32'b0001);
        tick();
        drive(4'b1111, 1'b1, 1'b0);
        chk("mid_g1", 32'(d_oht[0]), 32'b0010);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk("mid_lock", 32'(d_oht[0]), 32'b0100);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk("mid_lock2", 32'(d_oht[0]), 32'b0100);
        tick();
        drive(4'b1111, 1'b0, 1'b1);
        chk("mid_rst", 32'(d_oht[0]), 32'd0);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk("post_rst_l", 32'(d_oht[0]), 32'b0001);
        chk("post_rst_m", 32'(d_oht[2]), 32'b1000);
        tick();

        // Random traffic against the model.
        rr = 4'h0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0)
                rr = 4'($urandom);
            else
                rr = rr | (4'($urandom) & 4'($urandom) & 4'($urandom));
            ra  = ($urandom_range(0, 2) != 0);
            rrs = ($urandom_range(0, 199) == 0);
            drive(rr, ra, rrs);
            tick();
            if (g_cur[0] >= 0 && ra) rr[g_cur[0]] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
